// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port vector data memory between the core MEM stage and a host/DMA port.
// The core has priority; the host is served when the core idles, or forcibly after starving, for a bounded burst.
module dmem_port_arbiter #(
  parameter int unsigned MEM_WA     = 8,
  parameter int unsigned DSIZE      = 256,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [MEM_WA-1:0] core_addr,
  input  logic [DSIZE-1:0]  core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DSIZE-1:0]  core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [MEM_WA-1:0] host_addr,
  input  logic [DSIZE-1:0]  host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DSIZE-1:0]  host_rdata,
  output logic [MEM_WA-1:0] mem_addr,
  output logic [DSIZE-1:0]  mem_wdata,
  output logic              mem_we,
  input  logic [DSIZE-1:0]  mem_rdata
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX - 1);
  localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);

  logic [SW-1:0] starve_cnt, starve_cnt_n;
  logic [BW-1:0] burst_cnt, burst_cnt_n;
  logic          host_last;
  logic          rd_core_q, rd_host_q;
  logic          host_win;

  // Grant decision; nothing is issued while reset is asserted.
  always_comb begin
    host_win = 1'b0;
    core_gnt = 1'b0;
    if (!rst) begin
      host_win = host_req && (!core_req || (starve_cnt == STARVE_LIM) ||
                              (host_last && (burst_cnt < BURST_LIM)));
      core_gnt = core_req && !host_win;
    end
    host_gnt = host_win;
  end

  // Memory request mux: idle cycles present the core's address and data.
  always_comb begin
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
    mem_we = (core_gnt && core_we) || (host_gnt && host_we);
  end

  // Return steering; a read pending across reset is dropped.
  always_comb begin
    core_rvalid = rd_core_q && !rst;
    host_rvalid = rd_host_q && !rst;
    core_rdata  = mem_rdata;
    host_rdata  = mem_rdata;
  end

  // Starvation and burst counter updates.
  always_comb begin
    starve_cnt_n = '0;
    burst_cnt_n  = '0;
    if (host_req && !host_gnt) begin
      starve_cnt_n = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + SW'(1);
    end
    if (host_gnt) begin
      if (!host_last) begin
        burst_cnt_n = BW'(1);
      end else begin
        burst_cnt_n = (burst_cnt == BURST_LIM) ? burst_cnt : burst_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      burst_cnt  <= '0;
      host_last  <= 1'b0;
      rd_core_q  <= 1'b0;
      rd_host_q  <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_n;
      burst_cnt  <= burst_cnt_n;
      host_last  <= host_gnt;
      rd_core_q  <= core_gnt && !core_we;
      rd_host_q  <= host_gnt && !host_we;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a bench-side RAM, a behavioural arbitration/data model,
// directed scenarios and a randomized run.
module tb_dmem_port_arbiter;

  localparam int unsigned MEM_WA     = 8;
  localparam int unsigned DSIZE      = 256;
  localparam int unsigned STARVE_MAX = 8;
  localparam int unsigned BURST_MAX  = 4;
  localparam int unsigned DEPTH      = 1 << MEM_WA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              core_req, core_we, core_gnt, core_rvalid;
  logic [MEM_WA-1:0] core_addr;
  logic [DSIZE-1:0]  core_wdata, core_rdata;
  logic              host_req, host_we, host_gnt, host_rvalid;
  logic [MEM_WA-1:0] host_addr;
  logic [DSIZE-1:0]  host_wdata, host_rdata;
  logic [MEM_WA-1:0] mem_addr;
  logic [DSIZE-1:0]  mem_wdata, mem_rdata;
  logic              mem_we;

  dmem_port_arbiter #(
    .MEM_WA(MEM_WA), .DSIZE(DSIZE), .STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Single-port RAM with a registered read port.
  logic [DSIZE-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model state: expected memory contents, host waiting time, current host run length.
  logic [DSIZE-1:0] ref_mem [DEPTH];
  int               host_wait;
  int               burst_len;
  bit               pend_core, pend_host;
  logic [DSIZE-1:0] pend_data;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [DSIZE-1:0] obs, input logic [DSIZE-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [DSIZE-1:0] rand_word();
    logic [DSIZE-1:0] w;
    for (int i = 0; i < DSIZE / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // One clock cycle: drive at negedge, check against the model, advance the model at posedge.
  task automatic step(input bit r,
                      input bit cr, input bit cw, input logic [MEM_WA-1:0] ca, input logic [DSIZE-1:0] cd,
                      input bit hr, input bit hw, input logic [MEM_WA-1:0] ha, input logic [DSIZE-1:0] hd,
                      output bit hg_seen);
    bit eh, ec;
    @(negedge clk);
    rst = r;
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    #1;
    eh = 1'b0;
    ec = 1'b0;
    if (!r) begin
      eh = hr && (!cr || host_wait >= int'(STARVE_MAX) - 1 ||
                  (burst_len > 0 && burst_len < int'(BURST_MAX)));
      ec = cr && !eh;
    end
    check("host_gnt", DSIZE'(host_gnt), DSIZE'(eh));
    check("core_gnt", DSIZE'(core_gnt), DSIZE'(ec));
    check("mem_we", DSIZE'(mem_we), DSIZE'((ec && cw) || (eh && hw)));
    check("mem_addr", DSIZE'(mem_addr), DSIZE'(eh ? ha : ca));
    if (mem_we) check("mem_wdata", mem_wdata, eh ? hd : cd);
    check("core_rvalid", DSIZE'(core_rvalid), DSIZE'(!r && pend_core));
    check("host_rvalid", DSIZE'(host_rvalid), DSIZE'(!r && pend_host));
    if (!r && pend_core) check("core_rdata", core_rdata, pend_data);
    if (!r && pend_host) check("host_rdata", host_rdata, pend_data);
    hg_seen = host_gnt;
    @(posedge clk);
    if (r) begin
      host_wait = 0;
      burst_len = 0;
      pend_core = 1'b0;
      pend_host = 1'b0;
    end else begin
      host_wait = (hr && !eh) ? host_wait + 1 : 0;
      burst_len = eh ? ((burst_len < int'(BURST_MAX)) ? burst_len + 1 : burst_len) : 0;
      pend_core = ec && !cw;
      pend_host = eh && !hw;
      pend_data = ref_mem[eh ? ha : ca];
      if (ec && cw) ref_mem[ca] = cd;
      if (eh && hw) ref_mem[ha] = hd;
    end
  endtask

  initial begin
    bit               hg;
    int               first_host, host_runs, core_after;
    logic [DSIZE-1:0] x;
    logic [DSIZE-1:0] z;
    z = '0;
    host_wait = 0; burst_len = 0; pend_core = 1'b0; pend_host = 1'b0; pend_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram[i] = rand_word();
      ref_mem[i] = ram[i];
    end
    rst = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    // Reset with both requesting: no grants.
    step(1, 1, 0, 8'd1, z, 1, 0, 8'd2, z, hg);
    step(1, 0, 0, 8'd0, z, 0, 0, 8'd0, z, hg);

    // Core read, host idle, then return.
    step(0, 1, 0, 8'd5, z, 0, 0, 8'd0, z, hg);
    step(0, 0, 0, 8'd0, z, 0, 0, 8'd0, z, hg);

    // Starvation forces a host grant on the 8th waiting cycle, then a 4-grant burst.
    first_host = -1; host_runs = 0; core_after = 0;
    for (int c = 0; c < 14; c++) begin
      step(0, 1, 0, MEM_WA'(c), z, 1, 0, MEM_WA'(c + 32), z, hg);
      if (hg) begin
        if (first_host < 0) first_host = c;
        host_runs++;
      end else if (first_host >= 0) begin
        core_after++;
      end
    end
    check("starve_first_grant", DSIZE'(first_host), DSIZE'(STARVE_MAX - 1));
    check("burst_length", DSIZE'(host_runs), DSIZE'(BURST_MAX));
    check("core_resumes", DSIZE'(core_after), DSIZE'(14 - STARVE_MAX - BURST_MAX + 1));
    step(0, 0, 0, 8'd0, z, 0, 0, 8'd0, z, hg);

    // Host-only writes then pipelined reads back.
    for (int a = 0; a < 4; a++) step(0, 0, 0, 8'd0, z, 1, 1, MEM_WA'(a), rand_word(), hg);
    for (int a = 0; a < 4; a++) step(0, 0, 0, 8'd0, z, 1, 0, MEM_WA'(a), z, hg);
    step(0, 0, 0, 8'd0, z, 0, 0, 8'd0, z, hg);

    // Core write and host read of the same address collide; host sees the new data.
    x = rand_word();
    step(0, 1, 1, 8'd9, x, 1, 0, 8'd9, z, hg);
    step(0, 0, 0, 8'd0, z, 1, 0, 8'd9, z, hg);
    step(0, 0, 0, 8'd0, z, 0, 0, 8'd0, z, hg);
    check("collide_data", ref_mem[9], x);

    // Reset right after a granted core read drops the return.
    step(0, 1, 0, 8'd7, z, 0, 0, 8'd0, z, hg);
    step(1, 1, 0, 8'd7, z, 1, 0, 8'd8, z, hg);
    step(0, 0, 0, 8'd0, z, 0, 0, 8'd0, z, hg);

    // Randomized traffic over a small address window.
    for (int c = 0; c < 1000; c++) begin
      step(($urandom_range(63) == 0),
           1'($urandom), 1'($urandom), MEM_WA'($urandom_range(15)), rand_word(),
           1'($urandom), 1'($urandom), MEM_WA'($urandom_range(15)), rand_word(), hg);
    end
    step(0, 0, 0, 8'd0, z, 0, 0, 8'd0, z, hg);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
